// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the Ethernet receive MAC.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DROP
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state logic for the reflected IEEE 802.3 CRC-32.
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/mac_rx.sv
// Receive MAC: strips preamble/SFD, filters on destination, forwards payload
// and hides the FCS behind a 5-byte pipe so the last byte carries the CRC verdict.
//
// state     | meaning
// WAIT_IDLE | out of reset, wait for a gap before trusting rx_dv
// IDLE      | between frames, expecting the first preamble byte
// PREAMBLE  | inside preamble, waiting for SFD
// HEADER    | collecting destination, source and EtherType
// PAYLOAD   | streaming payload through the FCS-hiding pipe
// DROP      | discarding the rest of the frame until rx_dv falls
module mac_rx
    import mac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h000A_3501_FEC0,
    parameter bit          PROMISC   = 1'b0,
    parameter int          MAX_BYTES = 1504
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        out_ok,
    output logic        frame_err,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type
);

    localparam logic [10:0] MAX_CNT   = 11'(MAX_BYTES);
    localparam logic [10:0] HDR_LAST  = 11'(HDR_LEN - 1);
    localparam logic [2:0]  PIPE_FULL = 3'(FCS_LEN + 1);

    rx_state_e   state_q;
    logic [10:0] cnt_q;
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [39:0] pipe_q;
    logic [2:0]  fill_q;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [15:0] type_q;
    logic        first_done_q;
    logic        accept;
    logic        abort;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (rxd),
        .crc_o  (crc_nxt)
    );

    assign accept = PROMISC || (dst_q == LOCAL_MAC) || (dst_q == BCAST_MAC);

    // Errors only abort while a frame is being parsed; the counter check
    // catches the byte that would push the post-header length past MAX_BYTES.
    assign abort = rx_dv && (((state_q == HEADER) && rx_er) ||
                             ((state_q == PAYLOAD) && (rx_er || (cnt_q >= MAX_CNT))));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_IDLE;
            cnt_q        <= '0;
            crc_q        <= CRC_INIT;
            pipe_q       <= '0;
            fill_q       <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            type_q       <= '0;
            first_done_q <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_ok       <= 1'b0;
            frame_err    <= 1'b0;
            src_mac      <= '0;
            eth_type     <= '0;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_ok    <= 1'b0;
            frame_err <= 1'b0;

            if (abort) begin
                state_q   <= DROP;
                frame_err <= 1'b1;
                fill_q    <= '0;
                pipe_q    <= '0;
                if (first_done_q) begin
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    out_data  <= 8'h00;
                end
            end else begin
                case (state_q)
                    WAIT_IDLE: begin
                        if (!rx_dv) state_q <= IDLE;
                    end
                    IDLE: begin
                        if (rx_dv) begin
                            if (rxd == PREAMBLE_BYTE) begin
                                state_q <= PREAMBLE;
                            end else begin
                                state_q   <= DROP;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    PREAMBLE: begin
                        if (!rx_dv) begin
                            state_q   <= IDLE;
                            frame_err <= 1'b1;
                        end else if (rxd == SFD) begin
                            state_q      <= HEADER;
                            crc_q        <= CRC_INIT;
                            cnt_q        <= '0;
                            first_done_q <= 1'b0;
                        end else if (rxd != PREAMBLE_BYTE) begin
                            state_q   <= DROP;
                            frame_err <= 1'b1;
                        end
                    end
                    HEADER: begin
                        if (!rx_dv) begin
                            state_q   <= IDLE;
                            frame_err <= 1'b1;
                        end else begin
                            crc_q <= crc_nxt;
                            if (cnt_q < 11'd6)       dst_q  <= {dst_q[39:0], rxd};
                            else if (cnt_q < 11'd12) src_q  <= {src_q[39:0], rxd};
                            else                     type_q <= {type_q[7:0], rxd};
                            if (cnt_q == HDR_LAST) begin
                                cnt_q  <= '0;
                                fill_q <= '0;
                                if (accept) begin
                                    state_q  <= PAYLOAD;
                                    src_mac  <= src_q;
                                    eth_type <= {type_q[7:0], rxd};
                                end else begin
                                    state_q <= DROP;
                                end
                            end else begin
                                cnt_q <= cnt_q + 11'd1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (!rx_dv) begin
                            // The four youngest bytes are the FCS; the oldest is the last payload byte.
                            if (fill_q == PIPE_FULL) begin
                                out_valid <= 1'b1;
                                out_first <= !first_done_q;
                                out_last  <= 1'b1;
                                out_ok    <= (crc_q == CRC_RESIDUE);
                                out_data  <= pipe_q[39:32];
                            end else begin
                                frame_err <= 1'b1;
                            end
                            fill_q  <= '0;
                            pipe_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            crc_q  <= crc_nxt;
                            pipe_q <= {pipe_q[31:0], rxd};
                            if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
                            if (fill_q == PIPE_FULL) begin
                                out_valid    <= 1'b1;
                                out_first    <= !first_done_q;
                                out_data     <= pipe_q[39:32];
                                first_done_q <= 1'b1;
                            end else begin
                                fill_q <= fill_q + 3'd1;
                            end
                        end
                    end
                    DROP: begin
                        if (!rx_dv) state_q <= IDLE;
                    end
                    default: state_q <= WAIT_IDLE;
                endcase
            end
        end
    end

endmodule
